// File: rtl/pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_ctrl
// Brief    : Fetch-side PC controller that arbitrates trap/branch/jump
//            redirects, handles halting and runs a fetch watchdog.
//            Optional feature macro: PC_CTRL_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    input  logic        branch_valid_i,
    input  logic [31:0] branch_pc_i,
    input  logic        jump_valid_i,
    input  logic [31:0] jump_pc_i,
    input  logic        stall_i,
    input  logic        halt_req_i,
    input  logic        resume_i,
    input  logic        imem_ack_i,
    output logic        imem_req_o,
    output logic        pc_halt_o,
    output logic        pc_taken_o,
    output logic [31:0] pc_target_o,
    output logic        flush_o,
    output logic        fetch_err_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    localparam logic [1:0] c_PRIO_TRAP   = 2'd2;
    localparam logic [1:0] c_PRIO_BRANCH = 2'd1;
    localparam logic [1:0] c_PRIO_JUMP   = 2'd0;
    localparam logic [7:0] c_WD_LIMIT    = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_pend_vld, w_pend_vld_nxt;
    logic [31:0] r_pend_pc, w_pend_pc_nxt;
    logic [1:0]  r_pend_prio, w_pend_prio_nxt;
    logic        r_outst, w_outst_nxt;
    logic [7:0]  r_wd, w_wd_nxt;

    logic        w_new_vld;
    logic [31:0] w_new_pc;
    logic [1:0]  w_new_prio;
    logic        w_new_wins;
    logic        w_sel_vld;
    logic [31:0] w_sel_pc;
    logic [31:0] w_sel_tgt;
    logic        w_sel_mis;
    logic        w_hang;

    always_comb begin
        w_new_vld  = 1'b1;
        w_new_pc   = 32'd0;
        w_new_prio = c_PRIO_JUMP;
        if (trap_valid_i) begin
            w_new_pc   = trap_pc_i;
            w_new_prio = c_PRIO_TRAP;
        end else if (branch_valid_i) begin
            w_new_pc   = branch_pc_i;
            w_new_prio = c_PRIO_BRANCH;
        end else if (jump_valid_i) begin
            w_new_pc   = jump_pc_i;
            w_new_prio = c_PRIO_JUMP;
        end else begin
            w_new_vld  = 1'b0;
        end
    end

    // A new request beats a pending one of equal priority (newer wins ties).
    assign w_new_wins = w_new_vld & (~r_pend_vld | (w_new_prio >= r_pend_prio));
    assign w_sel_vld  = w_new_vld | r_pend_vld;
    assign w_sel_pc   = w_new_wins ? w_new_pc : r_pend_pc;

`ifdef PC_CTRL_MISALIGN_TRAP_EN
    assign w_sel_mis = |w_sel_pc[1:0];
    assign w_sel_tgt = w_sel_mis ? TRAP_VEC : w_sel_pc;
`else
    assign w_sel_mis = 1'b0;
    assign w_sel_tgt = {w_sel_pc[31:2], 2'b00};
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_pc_nxt   = r_pend_pc;
        w_pend_prio_nxt = r_pend_prio;
        w_outst_nxt     = 1'b0;
        w_wd_nxt        = 8'd0;
        w_hang          = 1'b0;
        imem_req_o      = 1'b0;
        pc_halt_o       = 1'b1;
        pc_taken_o      = 1'b0;
        pc_target_o     = 32'd0;
        flush_o         = 1'b0;
        fetch_err_o     = 1'b0;
        misalign_o      = 1'b0;

        case (r_state)
            S_RUN: begin
                imem_req_o = ~stall_i | r_outst;
                pc_halt_o  = ~imem_ack_i;
                w_hang     = imem_req_o & ~imem_ack_i;
                if (imem_ack_i) begin
                    if (w_sel_vld) begin
                        pc_taken_o     = 1'b1;
                        pc_target_o    = w_sel_tgt;
                        flush_o        = 1'b1;
                        misalign_o     = w_sel_mis;
                        w_pend_vld_nxt = 1'b0;
                    end
                end else if (w_new_wins) begin
                    w_pend_vld_nxt  = 1'b1;
                    w_pend_pc_nxt   = w_new_pc;
                    w_pend_prio_nxt = w_new_prio;
                end
                w_outst_nxt = w_hang;
                w_wd_nxt    = w_hang ? r_wd + 8'd1 : 8'd0;
                if (w_hang && (r_wd == c_WD_LIMIT)) begin
                    w_state_nxt = S_ERROR;
                end else if (halt_req_i && (imem_ack_i || !r_outst)) begin
                    // An unacknowledged request issued this cycle is abandoned.
                    w_state_nxt = S_HALTED;
                    w_outst_nxt = 1'b0;
                    w_wd_nxt    = 8'd0;
                end
            end
            S_HALTED: begin
                if (w_sel_vld) begin
                    pc_taken_o     = 1'b1;
                    pc_target_o    = w_sel_tgt;
                    misalign_o     = w_sel_mis;
                    w_pend_vld_nxt = 1'b0;
                end
                if (resume_i && !halt_req_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_ERROR: begin
                fetch_err_o    = 1'b1;
                w_pend_vld_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        if (!reset_i) begin
            imem_req_o  = 1'b0;
            pc_halt_o   = 1'b1;
            pc_taken_o  = 1'b0;
            pc_target_o = 32'd0;
            flush_o     = 1'b0;
            fetch_err_o = 1'b0;
            misalign_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state     <= S_RUN;
            r_pend_vld  <= 1'b0;
            r_pend_pc   <= 32'd0;
            r_pend_prio <= 2'd0;
            r_outst     <= 1'b0;
            r_wd        <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_pc   <= w_pend_pc_nxt;
            r_pend_prio <= w_pend_prio_nxt;
            r_outst     <= w_outst_nxt;
            r_wd        <= w_wd_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_ctrl
// Brief    : Self-checking bench for pc_ctrl: directed scenarios followed by
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_ctrl;

    localparam int          c_TO = 4;
    localparam logic [31:0] c_TV = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        trap_valid_i, branch_valid_i, jump_valid_i;
    logic [31:0] trap_pc_i, branch_pc_i, jump_pc_i;
    logic        stall_i, halt_req_i, resume_i, imem_ack_i;
    logic        imem_req_o, pc_halt_o, pc_taken_o, flush_o, fetch_err_o, misalign_o;
    logic [31:0] pc_target_o;

    pc_ctrl #(.TRAP_VEC(c_TV), .TIMEOUT(c_TO)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .trap_valid_i   (trap_valid_i),
        .trap_pc_i      (trap_pc_i),
        .branch_valid_i (branch_valid_i),
        .branch_pc_i    (branch_pc_i),
        .jump_valid_i   (jump_valid_i),
        .jump_pc_i      (jump_pc_i),
        .stall_i        (stall_i),
        .halt_req_i     (halt_req_i),
        .resume_i       (resume_i),
        .imem_ack_i     (imem_ack_i),
        .imem_req_o     (imem_req_o),
        .pc_halt_o      (pc_halt_o),
        .pc_taken_o     (pc_taken_o),
        .pc_target_o    (pc_target_o),
        .flush_o        (flush_o),
        .fetch_err_o    (fetch_err_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // PC register as the core would build it from the controller outputs.
    logic [31:0] pc_reg;
    always @(posedge clk_i) begin
        if (!reset_i)        pc_reg <= 32'd0;
        else if (pc_taken_o) pc_reg <= pc_target_o;
        else if (!pc_halt_o) pc_reg <= pc_reg + 32'd4;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0=running, 1=halted, 2=error.
    int          m_mode = 0;
    bit          m_pv = 0;
    logic [31:0] m_ppc = '0;
    int          m_ppr = 0;
    bit          m_busy = 0;
    int          m_wait = 0;
    int          m_best, m_newbest;
    logic        cv [4];
    logic [31:0] cp [4];
    int          cr [4];

    logic        e_req, e_halt, e_taken, e_flush, e_err, e_mis;
    logic [31:0] e_tgt;

    task automatic apply_redirect(input logic [31:0] raw);
        e_taken = 1'b1;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        if (raw[1:0] != 2'b00) begin
            e_tgt = c_TV;
            e_mis = 1'b1;
        end else begin
            e_tgt = raw;
        end
`else
        e_tgt = raw & 32'hFFFF_FFFC;
`endif
    endtask

    task automatic model_eval();
        cv[0] = trap_valid_i;   cp[0] = trap_pc_i;   cr[0] = 2;
        cv[1] = branch_valid_i; cp[1] = branch_pc_i; cr[1] = 1;
        cv[2] = jump_valid_i;   cp[2] = jump_pc_i;   cr[2] = 0;
        cv[3] = m_pv;           cp[3] = m_ppc;       cr[3] = m_ppr;
        m_best = -1;
        m_newbest = -1;
        for (int i = 0; i < 4; i++) begin
            if (cv[i] && (m_best < 0 || cr[i] > cr[m_best])) m_best = i;
            if (i < 3 && cv[i] && (m_newbest < 0 || cr[i] > cr[m_newbest])) m_newbest = i;
        end
        e_req = 0; e_halt = 1; e_taken = 0; e_tgt = '0; e_flush = 0; e_err = 0; e_mis = 0;
        if (reset_i) begin
            if (m_mode == 0) begin
                e_req  = !stall_i || m_busy;
                e_halt = !imem_ack_i;
                if (imem_ack_i && m_best >= 0) begin
                    apply_redirect(cp[m_best]);
                    e_flush = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (m_best >= 0) apply_redirect(cp[m_best]);
            end else begin
                e_err = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        bit hang;
        if (!reset_i) begin
            m_mode = 0; m_pv = 0; m_busy = 0; m_wait = 0;
        end else if (m_mode == 0) begin
            hang = e_req && !imem_ack_i;
            if (imem_ack_i) begin
                if (m_best >= 0) m_pv = 0;
            end else if (m_newbest >= 0 && (!m_pv || cr[m_newbest] >= m_ppr)) begin
                m_pv = 1; m_ppc = cp[m_newbest]; m_ppr = cr[m_newbest];
            end
            if (hang && m_wait == c_TO - 1) begin
                m_mode = 2;
            end else if (halt_req_i && (imem_ack_i || !m_busy)) begin
                m_mode = 1; m_busy = 0; m_wait = 0;
            end else begin
                m_busy = hang;
                m_wait = hang ? m_wait + 1 : 0;
            end
        end else if (m_mode == 1) begin
            if (m_best >= 0) m_pv = 0;
            if (resume_i && !halt_req_i) m_mode = 0;
        end else begin
            m_pv = 0;
        end
    endtask

    task automatic step(input string tag);
        logic [37:0] obs, expv;
        #3;
        model_eval();
        obs  = {imem_req_o, pc_halt_o, pc_taken_o, pc_target_o, flush_o, fetch_err_o, misalign_o};
        expv = {e_req, e_halt, e_taken, e_tgt, e_flush, e_err, e_mis};
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed {req,halt,taken,target,flush,err,mis}=%h expected=%h", tag, obs, expv);
        end
        model_commit();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] expv);
        n_cmp++;
        assert (pc_reg === expv) else begin
            n_bad++;
            $error("FAIL %s: observed pc=%h expected=%h", tag, pc_reg, expv);
        end
    endtask

    task automatic idle();
        trap_valid_i = 0; branch_valid_i = 0; jump_valid_i = 0;
        trap_pc_i = '0; branch_pc_i = '0; jump_pc_i = '0;
        stall_i = 0; halt_req_i = 0; resume_i = 0; imem_ack_i = 0;
    endtask

    initial begin
        // Reset with noisy inputs: outputs must stay at their reset values.
        idle();
        reset_i = 0; imem_ack_i = 1; trap_valid_i = 1; trap_pc_i = 32'h0000_0203;
        step("reset0");
        step("reset1");
        chk_pc("pc_after_reset", 32'd0);

        // Straight-line fetch, ack every cycle.
        idle(); reset_i = 1; imem_ack_i = 1;
        step("seq0"); chk_pc("pc_4", 32'd4);
        step("seq1"); chk_pc("pc_8", 32'd8);
        step("seq2"); chk_pc("pc_12", 32'd12);

        // Branch held pending across two unacked cycles.
        idle(); branch_valid_i = 1; branch_pc_i = 32'h40;
        step("br_latch");
        idle(); step("br_wait");
        imem_ack_i = 1; step("br_apply"); chk_pc("pc_br", 32'h40);
        step("br_after"); chk_pc("pc_br4", 32'h44);

        // Priority among simultaneous and pending redirects.
        idle(); imem_ack_i = 1;
        jump_valid_i = 1; jump_pc_i = 32'h80;
        branch_valid_i = 1; branch_pc_i = 32'h60;
        trap_valid_i = 1; trap_pc_i = 32'h200;
        step("prio_same"); chk_pc("pc_trap", 32'h200);
        idle(); jump_valid_i = 1; jump_pc_i = 32'h80; step("jmp_pend");
        idle(); branch_valid_i = 1; branch_pc_i = 32'h60; step("br_replace");
        idle(); imem_ack_i = 1; step("pend_apply"); chk_pc("pc_pend", 32'h60);

        // Halt with a fetch outstanding, redirect while halted, resume.
        idle(); step("outst");
        halt_req_i = 1; step("halt_wait");
        imem_ack_i = 1; step("halt_ack");
        idle(); halt_req_i = 1; resume_i = 1; step("halt_wins");
        idle(); jump_valid_i = 1; jump_pc_i = 32'h300; step("halted_redir");
        chk_pc("pc_halted", 32'h300);
        idle(); resume_i = 1; step("resume");
        idle(); step("run_req");
        imem_ack_i = 1; step("run_ack");

        // Misaligned branch target.
        idle(); imem_ack_i = 1; branch_valid_i = 1; branch_pc_i = 32'h42;
        step("misalign");
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        chk_pc("pc_mis", 32'h100);
`else
        chk_pc("pc_mis", 32'h40);
`endif

        // Watchdog timeout into ERROR, then recovery via reset.
        idle();
        for (int i = 0; i < c_TO; i++) step("wd_count");
        imem_ack_i = 1; trap_valid_i = 1; trap_pc_i = 32'h500; step("err_sticky");
        idle(); step("err_hold");
        reset_i = 0; step("err_reset");
        reset_i = 1; imem_ack_i = 1; step("post_reset");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset_i        = ($urandom_range(0, 24) != 0);
            trap_valid_i   = ($urandom_range(0, 7) == 0);
            branch_valid_i = ($urandom_range(0, 4) == 0);
            jump_valid_i   = ($urandom_range(0, 4) == 0);
            trap_pc_i      = $urandom();
            branch_pc_i    = $urandom();
            jump_pc_i      = $urandom();
            stall_i        = ($urandom_range(0, 3) == 0);
            halt_req_i     = ($urandom_range(0, 7) == 0);
            resume_i       = ($urandom_range(0, 2) == 0);
            imem_ack_i     = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
